// File: rtl/crc_check_serial.sv
`default_nettype none
// ============================================================================
// Module   : crc_check_serial
// Brief    : Bit-serial (MSB first) receive CRC checker; divides the codeword
//            by a per-frame latched generator and holds msg/remainder/pass flag
//            until the consumer takes them.
// Revision : 1.0 - initial release
// ============================================================================
module crc_check_serial #(
  parameter int MSG_W = 9,
  parameter int CRC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CRC_W:0]   genpoly,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MSG_W-1:0] out_msg,
  output logic [CRC_W-1:0] out_rem,
  output logic             out_ok
);

  localparam int c_code_w = MSG_W + CRC_W;
  localparam int c_cnt_w  = $clog2(c_code_w + 1);
  localparam logic [c_cnt_w-1:0] c_msg_cnt  = c_cnt_w'(MSG_W);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_code_w);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_base;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic [CRC_W-1:0]   r_rem;
  logic [CRC_W-1:0]   w_rem_base;
  logic [CRC_W-1:0]   w_rem_shift;
  logic [CRC_W-1:0]   w_rem_next;
  logic [CRC_W-1:0]   r_poly;
  logic [CRC_W-1:0]   w_poly;
  logic [MSG_W-1:0]   r_msg;
  logic [MSG_W-1:0]   w_msg_base;
  logic [MSG_W-1:0]   w_msg_shift;
  logic [MSG_W-1:0]   w_msg_next;
  logic               r_ok;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               w_xfer;
  logic               w_start;
  logic               w_last;
  logic               w_unused;

  // The x^CRC_W term of the generator is implicit, so its input bit is dropped.
  assign w_unused = genpoly[CRC_W];

  assign w_xfer  = in_valid && r_in_ready;
  assign w_start = w_xfer && ((r_state == IDLE) || in_sof);

  // A frame start behaves as if the accumulators were already cleared.
  assign w_cnt_base = w_start ? '0 : r_cnt;
  assign w_rem_base = w_start ? '0 : r_rem;
  assign w_msg_base = w_start ? '0 : r_msg;
  assign w_poly     = w_start ? genpoly[CRC_W-1:0] : r_poly;

  generate
    if (CRC_W > 1) begin : g_rem_wide
      assign w_rem_shift = {w_rem_base[CRC_W-2:0], in_bit};
    end else begin : g_rem_narrow
      assign w_rem_shift = in_bit;
    end
  endgenerate

  generate
    if (MSG_W > 1) begin : g_msg_wide
      assign w_msg_shift = {w_msg_base[MSG_W-2:0], in_bit};
    end else begin : g_msg_narrow
      assign w_msg_shift = in_bit;
    end
  endgenerate

  assign w_rem_next = w_rem_shift ^ (w_rem_base[CRC_W-1] ? w_poly : '0);
  assign w_cnt_next = w_cnt_base + c_cnt_one;
  assign w_msg_next = (w_cnt_base < c_msg_cnt) ? w_msg_shift : w_msg_base;
  assign w_last     = (w_cnt_next == c_last_cnt);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_state_next = w_last ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (w_xfer) begin
          w_state_next = w_last ? DONE : SHIFT;
        end
      end
      DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state, so out_ready
  // never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != DONE);
      r_out_valid <= (w_state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_msg  <= '0;
      r_poly <= '0;
      r_ok   <= 1'b1;
    end else if (w_xfer) begin
      r_cnt <= w_cnt_next;
      r_rem <= w_rem_next;
      r_msg <= w_msg_next;
      r_ok  <= (w_rem_next == '0);
      if (w_start) begin
        r_poly <= genpoly[CRC_W-1:0];
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_msg   = r_msg;
  assign out_rem   = r_rem;
  assign out_ok    = r_ok;

endmodule
`default_nettype wire
